// File: rtl/fetch_stage_if.sv
// Bundle of instruction-memory, hazard/redirect and IF/ID signals around the fetch stage.
// master = fetch stage, slave = memory + downstream pipeline (or a testbench).
interface fetch_stage_if;
    // imem: imem_req/imem_addr are a request that stays fixed until the memory
    // answers with imem_ready=1 in a cycle; imem_rdata is only meaningful then.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [3:0]  if_id_opcode;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc1;

    logic        dbg_state;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ready,
        input  stall, redirect_valid, redirect_target,
        output if_id_valid, if_id_instr, if_id_opcode, if_id_pc, if_id_pc1,
        output dbg_state
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ready,
        output stall, redirect_valid, redirect_target,
        input  if_id_valid, if_id_instr, if_id_opcode, if_id_pc, if_id_pc1,
        input  dbg_state
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, one outstanding imem read, IF/ID register,
// redirect handling with a DROP state that discards the response already in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.master bus
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc1_q, ifpc1_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0;
            ifpc_q       <= 32'h0;
            ifpc1_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            ifpc1_q      <= ifpc1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        ifpc1_d      = ifpc1_q;

        unique case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                    pc_d    = bus.redirect_target;
                    // A request still in flight must be answered before the new address can go out.
                    if (bus.imem_ready) fetch_addr_d = bus.redirect_target;
                    else                state_d      = DROP;
                end else if (bus.stall) begin
                    // hold everything; a completing read is simply reissued later
                end else if (bus.imem_ready) begin
                    valid_d      = 1'b1;
                    instr_d      = bus.imem_rdata;
                    ifpc_d       = fetch_addr_q;
                    ifpc1_d      = fetch_addr_q + 32'd1;
                    pc_d         = fetch_addr_q + 32'd1;
                    fetch_addr_d = fetch_addr_q + 32'd1;
                end else begin
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                end
            end
            DROP: begin
                valid_d = 1'b0;
                instr_d = 32'h0;
                if (bus.redirect_valid) pc_d = bus.redirect_target;
                if (bus.imem_ready) begin
                    fetch_addr_d = pc_d;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.imem_req     = ~rst;
    assign bus.imem_addr    = fetch_addr_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_opcode = instr_q[31:28];
    assign bus.if_id_pc     = ifpc_q;
    assign bus.if_id_pc1    = ifpc1_q;
    assign bus.dbg_state    = (state_q == DROP);

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address of the first fetch after reset.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word address of the outstanding request.
REQ-006 imem_rdata  in  32  instruction word; valid only when imem_ready=1.
REQ-007 imem_ready  in  1  request complete this cycle; zero or more wait cycles allowed.
REQ-008 stall  in  1  hazard hold from decode: IF/ID register and PC frozen.
REQ-009 redirect_valid  in  1  taken jump/branch/jump_mem resolved downstream.
REQ-010 redirect_target  in  32  new PC when redirect_valid=1.
REQ-011 if_id_valid  out  1  IF/ID holds a real instruction.
REQ-012 if_id_instr  out  32  fetched instruction; 32'h0 (NOP) when invalid.
REQ-013 if_id_opcode  out  4  if_id_instr[31:28], feeds the control unit opcode input.
REQ-014 if_id_pc  out  32  address of if_id_instr.
REQ-015 if_id_pc1  out  32  if_id_pc+1, consumed by SVPC and PC logic.

Function
REQ-016 PC is word-addressed; increment is +1 modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-017 imem_req SHALL be 1 in every cycle after reset is released; imem_addr SHALL come from a register (fetch_addr) and stay stable until imem_ready=1.
REQ-018 FSM states: FETCH (normal) and DROP (discard one stale response); reset state FETCH.
REQ-019 Priority per edge: redirect_valid, then stall, then imem_ready.
REQ-020 FETCH, redirect_valid=1, imem_ready=1: response discarded; fetch_addr<=pc<=redirect_target; IF/ID<=bubble; stay FETCH.
REQ-021 FETCH, redirect_valid=1, imem_ready=0: pc<=redirect_target; fetch_addr unchanged; IF/ID<=bubble; go DROP.
REQ-022 DROP: IF/ID<=bubble every cycle; on imem_ready=1 discard data, fetch_addr<=pc, go FETCH; a further redirect in DROP only updates pc.
REQ-023 FETCH, stall=1, no redirect: IF/ID, pc and fetch_addr hold; an imem_ready pulse is ignored and the same address is reissued (reads are side-effect free).
REQ-024 FETCH, no stall, imem_ready=1: if_id_valid<=1, if_id_instr<=imem_rdata, if_id_pc<=fetch_addr, if_id_pc1<=fetch_addr+1, pc<=fetch_addr<=fetch_addr+1.
REQ-025 FETCH, no stall, imem_ready=0: IF/ID<=bubble; pc and fetch_addr hold.
REQ-026 Bubble means if_id_valid=0, if_id_instr=32'h0, if_id_pc and if_id_pc1 held at previous values.
REQ-027 Throughput: one instruction per cycle with zero-wait memory; fetch-to-IF/ID latency is 1 edge after imem_ready.
REQ-028 Redirect-to-target-instruction latency: 2 edges with zero-wait memory.

Reset
REQ-029 While rst=1: imem_req=0, pc=fetch_addr=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc1=0.
REQ-030 rst asserted mid-wait or in DROP SHALL abandon the request immediately; the first request after release is RESET_PC.

Verification
REQ-031 Reset release, imem_ready=1 always, rdata=addr<<4 -> if_id_pc 0,1,2,3 on successive edges with instr 0x0,0x10,0x20,0x30, valid=1.
REQ-032 imem_ready low 2 cycles at addr 5 -> two bubbles (opcode 0000), imem_addr stays 5, then if_id_pc=5.
REQ-033 stall=1 for 3 cycles with IF/ID holding pc 7 -> if_id_* unchanged, imem_addr stays 8, resumes with pc 8.
REQ-034 redirect_valid with target 0x40 while imem_ready=0 at addr 9 -> DROP; addr 9 response discarded; next valid if_id_pc=0x40.
REQ-035 redirect and stall same cycle, target 0x20 -> bubble in IF/ID, next valid if_id_pc=0x20.
REQ-036 RESET_PC=32'hFFFF_FFFF -> if_id_pc FFFF_FFFF with pc1=0, next if_id_pc=0.
